// File: rtl/dtpu_vmac.sv
// Precision-configurable SIMD MAC: DATA_WIDTH split into 8/16/32/64-bit signed lanes,
// two-stage MUL/ACC pipeline, per-lane saturation to lane width, valid/ready both sides.
module dtpu_vmac #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclr,
   input  logic [1:0]            select_precision,
   input  logic [LEN_WIDTH-1:0]  acc_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] input_data,
   input  logic [DATA_WIDTH-1:0] weight,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] res_mac,
   output logic                  sat
);
   localparam int NL = DATA_WIDTH / 8;
   localparam int PW = 128;
   localparam int AW = PW + LEN_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              prec_q, prec_d, prec_e;
   logic [LEN_WIDTH-1:0]    len_q, len_d, cnt_q, cnt_d;
   logic signed [PW-1:0]    prod_d [NL];
   logic signed [PW-1:0]    prod_q [NL];
   logic signed [AW-1:0]    acc_q  [NL];
   logic                    pvld_q, pfirst_q;
   logic [DATA_WIDTH-1:0]   res_d, res_q;
   logic                    sat_d, sat_q;
   logic [64:0]             cl;
   logic                    accept, first;

   // Returns {clamped, value}; the low w bits of value are the saturated lane.
   function automatic logic [64:0] clampf(input logic signed [AW-1:0] a, input int w);
      logic signed [AW-1:0] mx;
      mx = (AW'(1) << (w - 1)) - AW'(1);
      if (a > mx)  return {1'b1, mx[63:0]};
      if (a < ~mx) return {1'b1, ~mx[63:0]};
      return {1'b0, a[63:0]};
   endfunction

   assign in_ready  = !reset && (state_q == IDLE || state_q == ACCUM);
   assign accept    = in_valid && in_ready;
   assign first     = (state_q == IDLE);
   // The first beat of a vector already multiplies at the newly selected precision.
   assign prec_e    = first ? select_precision : prec_q;
   assign out_valid = (state_q == OUTPUT);
   assign res_mac   = res_q;
   assign sat       = sat_q;

   always_comb begin
      state_d = state_q;
      prec_d  = prec_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            prec_d  = select_precision;
            len_d   = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
            cnt_d   = LEN_WIDTH'(1);
            state_d = (acc_len <= LEN_WIDTH'(1)) ? DRAIN : ACCUM;
         end
         ACCUM: if (accept) begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
            if (cnt_d == len_q) state_d = DRAIN;
         end
         DRAIN:   if (!pvld_q) state_d = OUTPUT;
         OUTPUT:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NL; i++) prod_d[i] = '0;
      case (prec_e)
         2'd0: for (int i = 0; i < NL; i++)
            prod_d[i] = PW'($signed(input_data[i*8 +: 8])) * PW'($signed(weight[i*8 +: 8]));
         2'd1: for (int i = 0; i < NL/2; i++)
            prod_d[i] = PW'($signed(input_data[i*16 +: 16])) * PW'($signed(weight[i*16 +: 16]));
         2'd2: for (int i = 0; i < NL/4; i++)
            prod_d[i] = PW'($signed(input_data[i*32 +: 32])) * PW'($signed(weight[i*32 +: 32]));
         default: for (int i = 0; i < NL/8; i++)
            prod_d[i] = PW'($signed(input_data[i*64 +: 64])) * PW'($signed(weight[i*64 +: 64]));
      endcase
   end

   always_comb begin
      res_d = '0;
      sat_d = 1'b0;
      cl    = '0;
      case (prec_q)
         2'd0: for (int i = 0; i < NL; i++) begin
            cl = clampf(acc_q[i], 8);   res_d[i*8 +: 8]   = cl[7:0];  sat_d = sat_d | cl[64];
         end
         2'd1: for (int i = 0; i < NL/2; i++) begin
            cl = clampf(acc_q[i], 16);  res_d[i*16 +: 16] = cl[15:0]; sat_d = sat_d | cl[64];
         end
         2'd2: for (int i = 0; i < NL/4; i++) begin
            cl = clampf(acc_q[i], 32);  res_d[i*32 +: 32] = cl[31:0]; sat_d = sat_d | cl[64];
         end
         default: for (int i = 0; i < NL/8; i++) begin
            cl = clampf(acc_q[i], 64);  res_d[i*64 +: 64] = cl[63:0]; sat_d = sat_d | cl[64];
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         prec_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         pvld_q   <= 1'b0;
         pfirst_q <= 1'b0;
         res_q    <= '0;
         sat_q    <= 1'b0;
         for (int i = 0; i < NL; i++) begin
            prod_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else if (sclr) begin
         state_q  <= IDLE;
         prec_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         pvld_q   <= 1'b0;
         pfirst_q <= 1'b0;
         res_q    <= '0;
         sat_q    <= 1'b0;
         for (int i = 0; i < NL; i++) begin
            prod_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         prec_q  <= prec_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         pvld_q  <= accept;
         if (accept) begin
            pfirst_q <= first;
            for (int i = 0; i < NL; i++) prod_q[i] <= prod_d[i];
         end
         // First product of a vector overwrites the accumulator, so no clear is needed.
         if (pvld_q)
            for (int i = 0; i < NL; i++)
               acc_q[i] <= pfirst_q ? AW'(prod_q[i]) : acc_q[i] + AW'(prod_q[i]);
         if (state_q == DRAIN && !pvld_q) begin
            res_q <= res_d;
            sat_q <= sat_d;
         end
      end
   end
endmodule

// File: tb/tb_dtpu_vmac.sv
// Scoreboard bench for dtpu_vmac (DATA_WIDTH=64): expected {sat,res} queued per vector,
// popped on each output handshake; plus latency, back-pressure and abort checks.
module tb_dtpu_vmac;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sclr = 1'b0;
   logic [1:0]  select_precision = '0;
   logic [7:0]  acc_len = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] input_data = '0;
   logic [63:0] weight = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] res_mac;
   logic        sat;

   int n_tot = 0;
   int n_bad = 0;
   logic [64:0] sb_q[$];

   dtpu_vmac #(.DATA_WIDTH(64), .LEN_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .sclr(sclr), .select_precision(select_precision),
      .acc_len(acc_len), .in_valid(in_valid), .in_ready(in_ready),
      .input_data(input_data), .weight(weight), .out_valid(out_valid),
      .out_ready(out_ready), .res_mac(res_mac), .sat(sat));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference for 8/16-bit lanes: n identical beats, clamp to lane width.
   function automatic logic [64:0] model(input int p, input int n, input logic [63:0] a, input logic [63:0] b);
      int          w;
      logic [63:0] r;
      logic        s;
      w = 8 << p;
      r = '0;
      s = 1'b0;
      for (int l = 0; l < 64 / w; l++) begin
         longint av, bv, acc, hi, lo, c;
         av  = longint'(a >> (l * w));
         bv  = longint'(b >> (l * w));
         av  = (av <<< (64 - w)) >>> (64 - w);
         bv  = (bv <<< (64 - w)) >>> (64 - w);
         acc = av * bv * longint'(n);
         hi  = (longint'(1) <<< (w - 1)) - 1;
         lo  = -hi - 1;
         c   = acc;
         if (acc > hi) begin c = hi; s = 1'b1; end
         if (acc < lo) begin c = lo; s = 1'b1; end
         r = r | ((64'(c) & ((64'd1 << w) - 64'd1)) << (l * w));
      end
      return {s, r};
   endfunction

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("sb_underflow", 65'(sb_q.size()), 65'd1);
         else chk("result", {sat, res_mac}, sb_q.pop_front());
      end
   end

   // Drives one beat (called at posedge+1) and returns at posedge+1 after it is accepted.
   task automatic beat(input logic [1:0] p, input logic [7:0] len, input logic [63:0] a, input logic [63:0] b);
      int k;
      k = 0;
      select_precision = p;
      acc_len          = len;
      input_data       = a;
      weight           = b;
      in_valid         = 1'b1;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 40);
      chk("beat_accept", in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Full vector; beats after the first carry garbage config to prove the latch.
   task automatic vec(input logic [1:0] p, input logic [7:0] len, input int nb,
                      input logic [63:0] a, input logic [63:0] b, input int gap, input logic [64:0] exp);
      sb_q.push_back(exp);
      for (int i = 0; i < nb; i++) begin
         if (i == 0) beat(p, len, a, b);
         else        beat(~p, 8'd1, a, b);
         if (i < nb - 1 && gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
         end
      end
      in_valid = 1'b0;
      @(negedge clk); chk("lat_e1", out_valid, 1'b0);
      @(negedge clk); chk("lat_e2", out_valid, 1'b0);
      @(negedge clk); chk("lat_e3", out_valid, 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      chk("watchdog", 65'(n_tot), 65'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  p;
      logic [7:0]  len;
      logic [63:0] a, b;
      int          nb;

      #2 chk("rst_in_ready_asserted", in_ready, 1'b0);
      #20 reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_res", res_mac, 64'd0);
      chk("rst_sat", sat, 1'b0);

      vec(2'd0, 8'd1, 1, {8{8'h03}}, {8{8'h04}}, 0, {1'b0, 64'h0C0C0C0C0C0C0C0C});
      vec(2'd0, 8'd4, 4, {8{8'h7F}}, {8{8'h7F}}, 0, {1'b1, {8{8'h7F}}});
      vec(2'd0, 8'd4, 4, {8{8'h7F}}, {8{8'h80}}, 0, {1'b1, {8{8'h80}}});
      vec(2'd1, 8'd2, 2, 64'h000000000000FFFE, 64'h0000000000000003, 0, {1'b0, 64'h000000000000FFF4});
      vec(2'd3, 8'd3, 3, 64'h0000000100000000, 64'd2, 1, {1'b0, 64'h0000000600000000});
      vec(2'd0, 8'd0, 1, {8{8'h05}}, {8{8'hFD}}, 0, {1'b0, {8{8'hF1}}});

      // Back-pressure: result must hold while a new beat waits.
      out_ready = 1'b0;
      vec(2'd0, 8'd1, 1, {8{8'h03}}, {8{8'h04}}, 0, {1'b0, 64'h0C0C0C0C0C0C0C0C});
      select_precision = 2'd0; acc_len = 8'd1;
      input_data = {8{8'h11}}; weight = {8{8'h11}}; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_res", {sat, res_mac}, {1'b0, 64'h0C0C0C0C0C0C0C0C});
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_post_in_ready", in_ready, 1'b1);
      chk("bp_post_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;

      // Asynchronous reset two beats into a four-beat vector.
      beat(2'd0, 8'd4, {8{8'h10}}, {8{8'h10}});
      beat(2'd0, 8'd1, {8{8'h10}}, {8{8'h10}});
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_res", {sat, res_mac}, 65'd0);
      chk("arst_in_ready", in_ready, 1'b0);
      #10 reset = 1'b0;
      @(posedge clk); #1;
      vec(2'd0, 8'd1, 1, {8{8'h02}}, {8{8'h02}}, 0, {1'b0, {8{8'h04}}});

      // sclr coincident with the final beat: no result may appear.
      beat(2'd1, 8'd2, {4{16'h0100}}, {4{16'h0100}});
      sclr = 1'b1;
      beat(2'd2, 8'd1, {4{16'h0100}}, {4{16'h0100}});
      sclr = 1'b0;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("sclr_no_out", out_valid, 1'b0);
      chk("sclr_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      vec(2'd1, 8'd2, 2, {4{16'h0100}}, {4{16'h0100}}, 0, model(1, 2, {4{16'h0100}}, {4{16'h0100}}));

      for (int r = 0; r < 6; r++) begin
         p   = 2'($urandom_range(1, 0));
         len = 8'($urandom_range(4, 0));
         nb  = (len == 0) ? 1 : int'(len);
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         vec(p, len, nb, a, b, int'($urandom_range(1, 0)), model(int'(p), nb, a, b));
      end

      repeat (3) @(posedge clk);
      chk("sb_drained", 65'(sb_q.size()), 65'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule

// File: doc/dtpu_vmac.md
# dtpu_vmac

Parametrised, precision-configurable SIMD multiply-accumulate engine for the DTPU datapath. It generalises the fixed 8/8/16/32 sub-MAC chain to DATA_WIDTH bits split uniformly into 8-, 16-, 32- or 64-bit signed lanes. It accumulates a programmable-length dot product per lane through a two-stage pipeline with valid/ready handshakes on both sides. Each lane's result is saturated to lane width, and a sticky overflow flag is returned. It sits between the weight/activation fetch buffers and the result write-back FIFO.

## Interface
Parameters:
- DATA_WIDTH, 64: datapath width; multiple of 64.
- LEN_WIDTH, 8: width of acc_len; max vector length 2^LEN_WIDTH-1.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear, active-high; aborts current vector.
- select_precision  in  2  lane width: 0=8, 1=16, 2=32, 3=64 bits.
- acc_len  in  LEN_WIDTH  beats per dot product; 0 treated as 1.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- input_data  in  DATA_WIDTH  activations, packed lanes, lane 0 at LSBs.
- weight  in  DATA_WIDTH  weights, same packing.
- out_valid  out  1  res_mac valid.
- out_ready  in  1  consumer accepts result.
- res_mac  out  DATA_WIDTH  per-lane saturated results, same packing.
- sat  out  1  at least one lane saturated in this result.

## Operation
- Lane count: L = DATA_WIDTH/w, where w = 8<<select_precision. All lanes are signed two's complement.
- Beat accept: in_valid & in_ready.
- Configuration latch: select_precision and acc_len are sampled on the first accepted beat of a vector. They are ignored for the rest of that vector.
- Stage 1 (MUL): registers full 2w-bit signed product per lane.
- Stage 2 (ACC): per-lane accumulator, width 2w+LEN_WIDTH, sign-extended add.
- The first beat of a vector loads the product into the accumulator; there is no prior clear.
- Beat counter: counts accepted beats. The vector completes on the beat where count == max(acc_len,1).
- Result: lane = clamp(acc, -2^(w-1), 2^(w-1)-1).
- sat = OR over lanes of (clamp applied).
- Accumulators never wrap. The guard bits cover the maximum length.
- FSM:
  - IDLE: in_ready=1. First accepted beat -> ACCUM, or -> DRAIN if len==1.
  - ACCUM: in_ready=1. Accepted final beat -> DRAIN.
  - DRAIN: in_ready=0. The final product enters ACC; next cycle -> OUTPUT.
  - OUTPUT: out_valid=1; res_mac and sat are held stable. out_valid & out_ready -> IDLE.
- In ACCUM, in_valid low simply stalls; the pipeline holds its state.
- sclr (any state): next edge -> IDLE. Counter, accumulators, pipeline and output registers are zeroed. sclr has priority over a simultaneous beat accept or output handshake.
- reset: same effect as sclr, asynchronous.

## Timing
- Reset values: in_ready=1 after reset deassertion (0 while reset asserted); out_valid=0; res_mac=0; sat=0; FSM=IDLE.
- Latency: final beat accepted at edge t -> out_valid=1 after edge t+2.
- Throughput: one beat/cycle within a vector. Minimum 3 dead cycles between vectors (DRAIN, ACC settle, OUTPUT handshake).
- Back-pressure: while out_valid & !out_ready, res_mac and sat must not change, and in_ready stays 0.
- The out handshake completes at edge e. in_ready=1 in cycle e+1. A beat is not accepted in the same cycle as the out handshake.
- select_precision changes mid-vector have no effect until the next IDLE->ACCUM transition.

## Test plan
- DATA_WIDTH=64, 8-bit mode, acc_len=1, all lanes input 0x03, weight 0x04 -> res_mac=0x0C0C0C0C0C0C0C0C, sat=0, out_valid 2 edges after accept.
- 8-bit mode, acc_len=4, all lanes 0x7F*0x7F each beat (sum 64516) -> every lane 0x7F, sat=1. Repeat with weight 0x80, input 0x7F -> every lane 0x80, sat=1.
- 16-bit mode, acc_len=2, lane 0 input 0xFFFE, weight 0x0003 both beats; other lanes 0 -> res_mac=0x000000000000FFF4, sat=0.
- 64-bit mode, acc_len=3, input 0x0000000100000000, weight 2, in_valid gapped (1,0,1,0,1) -> res_mac=0x0000000600000000, sat=0, out_valid 2 edges after third accept.
- Back-pressure: hold out_ready=0 for 5 cycles in OUTPUT with in_valid=1 -> res_mac and sat stable, in_ready=0, no beat consumed. Raise out_ready -> one handshake, then in_ready=1 next cycle.
- Abort paths:
  - Assert reset asynchronously mid-ACCUM (2 of 4 beats in) -> out_valid=0 and res_mac=0 immediately. A fresh acc_len=1 vector (0x02*0x02, 8-bit) then yields 0x04 per lane.
  - sclr coincident with the final beat of a vector -> no result; next vector unaffected.
